// File: rtl/ctech_lib_or_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ctech_lib_or_req_arbiter
// Purpose  : Round-robin arbiter sharing one downstream resource between N
//            requesters. Registered one-hot grant, held until acknowledged,
//            with an optional lock that keeps ownership across transfers.
// Options  : CTECH_LIB_OR_ARB_WDOG_EN - adds a hold watchdog that forces a
//            release after WDOG_CYC cycles without an acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module ctech_lib_or_req_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int WDOG_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [N-1:0]     req,
    input  logic             ack,
    input  logic             lock,
    output logic [N-1:0]     gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req,
    output logic             wdog_to
);

    // Elaboration-time guard on the legal parameter ranges.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("ctech_lib_or_req_arbiter: N must be in 2..16");
    end
    if (WDOG_CYC < 2 || WDOG_CYC > 255) begin : g_bad_wdog
        $error("ctech_lib_or_req_arbiter: WDOG_CYC must be in 2..255");
    end

    localparam logic [N-1:0]     c_ONE      = N'(1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   c_N_EXT    = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] r_ptr;

    logic             w_busy;
    logic             w_any_req;
    logic             w_wdog_fire;
    logic             w_release;
    logic             w_withdraw;
    logic [IDX_W-1:0] w_next_ptr;
    logic [IDX_W-1:0] w_arb_ptr;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_found;
    logic [N-1:0]     w_win_oh;

    assign w_any_req = |req;
    assign w_busy    = (r_state != S_IDLE);

    // Pointer after a release: one past the current winner, wrapping at N-1.
    assign w_next_ptr = (r_gnt_idx == c_LAST_IDX) ? '0 : r_gnt_idx + IDX_W'(1);

    // A release always re-arbitrates from the post-release pointer so the
    // outgoing winner becomes lowest priority; from IDLE the stored one is used.
    assign w_arb_ptr = w_busy ? w_next_ptr : r_ptr;

    // Acknowledge without lock, or a watchdog expiry, hands the resource on.
    assign w_release = w_busy && ((ack && !lock) || w_wdog_fire);

    // Only an unlocked grant may be abandoned by its requester; ack wins.
    assign w_withdraw = (r_state == S_GRANT) && !ack && !req[r_gnt_idx];

    // Circular first-one search starting at w_arb_ptr.
    always_comb begin
        logic [IDX_W:0] w_pos;
        w_pos       = '0;
        w_win_idx   = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, w_arb_ptr} + (IDX_W + 1)'(k);
            if (w_pos >= c_N_EXT) begin
                w_pos = w_pos - c_N_EXT;
            end
            if (!w_win_found && req[w_pos[IDX_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_pos[IDX_W-1:0];
            end
        end
    end

    assign w_win_oh = c_ONE << w_win_idx;

`ifdef CTECH_LIB_OR_ARB_WDOG_EN
    localparam logic [7:0] c_WDOG_LAST = 8'(WDOG_CYC - 1);

    logic [7:0] r_wdog_cnt;

    // Forced release fires in the cycle the hold count reaches its limit.
    assign w_wdog_fire = w_busy && !ack && (r_wdog_cnt == c_WDOG_LAST);

    // Hold counter: counts unacknowledged busy cycles, cleared otherwise.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wdog_cnt <= 8'd0;
        end else if (w_busy && !ack && !w_wdog_fire) begin
            r_wdog_cnt <= r_wdog_cnt + 8'd1;
        end else begin
            r_wdog_cnt <= 8'd0;
        end
    end

    assign wdog_to = w_wdog_fire;
`else
    assign w_wdog_fire = 1'b0;
    assign wdog_to     = 1'b0;
`endif

    // Arbitration state machine with registered grant, index and pointer.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt     <= w_win_oh;
                        r_gnt_idx <= w_win_idx;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT, S_LOCKED: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_any_req) begin
                            r_gnt     <= w_win_oh;
                            r_gnt_idx <= w_win_idx;
                            r_state   <= S_GRANT;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (ack && lock) begin
                        r_state <= S_LOCKED;
                    end else if (w_withdraw) begin
                        // Index keeps its last value while no grant is valid.
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = |r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign any_req = w_any_req;

endmodule
`default_nettype wire

// File: tb/tb_ctech_lib_or_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctech_lib_or_req_arbiter
// Purpose  : Self-checking bench for ctech_lib_or_req_arbiter (N=4) using a
//            directed vector table plus hand-written reset/lock/watchdog runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctech_lib_or_req_arbiter;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int WDOG_CYC = 16;
    localparam int NVEC     = 25;

`ifdef CTECH_LIB_OR_ARB_WDOG_EN
    localparam bit c_WDOG = 1'b1;
`else
    localparam bit c_WDOG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_b;
    logic [N-1:0]     req;
    logic             ack;
    logic             lock;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             any_req;
    logic             wdog_to;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] req;
        logic       ack;
        logic       lock;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl [0:NVEC-1];

    always #5 clk = ~clk;

    ctech_lib_or_req_arbiter #(
        .N        (N),
        .WDOG_CYC (WDOG_CYC)
    ) u_dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .req     (req),
        .ack     (ack),
        .lock    (lock),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .any_req (any_req),
        .wdog_to (wdog_to)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic a, input logic l);
        req  = r;
        ack  = a;
        lock = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string nm, input logic [3:0] g, input logic [1:0] i);
        chk({nm, " gnt"},     32'(gnt),     32'(g));
        chk({nm, " gnt_idx"}, 32'(gnt_idx), 32'(i));
        chk({nm, " gnt_vld"}, 32'(gnt_vld), 32'(|g));
    endtask

    initial begin
        // {req, ack, lock, expected gnt, expected idx} after the next edge
        tbl[0]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0};  // first grant from ptr 0
        tbl[1]  = '{4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2};  // back-to-back, no bubble
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0};  // wrap N-1 -> 0
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0};  // held without ack
        tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1};
        tbl[10] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};  // enter LOCKED
        tbl[11] = '{4'b1101, 1'b0, 1'b0, 4'b0010, 2'd1};  // req drop ignored
        tbl[12] = '{4'b1101, 1'b0, 1'b1, 4'b0010, 2'd1};  // lock without ack
        tbl[13] = '{4'b1101, 1'b1, 1'b1, 4'b0010, 2'd1};  // stay LOCKED
        tbl[14] = '{4'b1101, 1'b1, 1'b0, 4'b0100, 2'd2};  // release -> after 1
        tbl[15] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3};
        tbl[16] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3};  // withdrawal, idx held
        tbl[17] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3};  // ptr unchanged -> 3
        tbl[18] = '{4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1};  // ack beats withdrawal
        tbl[19] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1};  // release to IDLE
        tbl[20] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1};  // ack ignored in IDLE
        tbl[21] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0};  // ptr 2 wraps to 0
        tbl[22] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1};
        tbl[23] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1};  // sole requester regranted
        tbl[24] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1};  // withdrawal

        rst_b = 1'b0;
        req   = '0;
        ack   = 1'b0;
        lock  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_gnt("reset", 4'b0000, 2'd0);
        chk("reset wdog_to", 32'(wdog_to), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].req, tbl[i].ack, tbl[i].lock);
            chk($sformatf("row%0d any_req", i), 32'(any_req), 32'(|tbl[i].req));
            chk($sformatf("row%0d wdog_to", i), 32'(wdog_to), 32'd0);
            tick();
            chk_gnt($sformatf("row%0d", i), tbl[i].gnt, tbl[i].idx);
        end

        // Asynchronous reset in LOCKED, then pointer restarts at 0
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        chk_gnt("pre_rst grant", 4'b0100, 2'd2);
        drive(4'b0100, 1'b1, 1'b1);
        tick();
        chk_gnt("pre_rst locked", 4'b0100, 2'd2);
        #2;
        rst_b = 1'b0;
        #1;
        chk_gnt("async_rst", 4'b0000, 2'd0);
        chk("async_rst wdog_to", 32'(wdog_to), 32'd0);
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        chk_gnt("post_rst idle", 4'b0000, 2'd0);
        drive(4'b0010, 1'b0, 1'b0);
        tick();
        chk_gnt("post_rst req1", 4'b0010, 2'd1);
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        chk_gnt("post_rst drop", 4'b0000, 2'd1);
        drive(4'b0110, 1'b0, 1'b0);
        tick();
        chk_gnt("post_rst ptr0", 4'b0010, 2'd1);

        // Watchdog: lock held, no ack for WDOG_CYC cycles
        drive(4'b0110, 1'b1, 1'b1);
        tick();
        chk_gnt("wdog lock", 4'b0010, 2'd1);
        for (int j = 1; j <= WDOG_CYC; j++) begin
            drive(4'b0110, 1'b0, 1'b1);
            chk($sformatf("wdog c%0d wdog_to", j), 32'(wdog_to),
                32'(c_WDOG && (j == WDOG_CYC)));
            tick();
            if (c_WDOG && (j == WDOG_CYC)) begin
                chk_gnt($sformatf("wdog c%0d", j), 4'b0100, 2'd2);
            end else begin
                chk_gnt($sformatf("wdog c%0d", j), 4'b0010, 2'd1);
            end
        end
        drive(4'b0110, 1'b0, 1'b1);
        chk("wdog after wdog_to", 32'(wdog_to), 32'd0);
        tick();
        if (c_WDOG) begin
            chk_gnt("wdog after", 4'b0100, 2'd2);
        end else begin
            chk_gnt("wdog after", 4'b0010, 2'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctech_lib_or_req_arbiter.md
Name: ctech_lib_or_req_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between N requesters.
- The request vector is OR-reduced into a single "any request" term; one registered, one-hot grant is issued per arbitration.
- Grants are held until the winner acknowledges. A lock input lets the winner keep ownership across multiple transfers.
- Standard ctech-library building block, instantiated wherever several agents drive one shared ctech datapath cell or port.

Parameters:
- N, 4, number of requesters (legal range 2..16)
- IDX_W, $clog2(N), width of the encoded grant index (derived; do not override)
- WDOG_CYC, 16, watchdog hold limit in cycles (legal range 2..255; used only when the watchdog macro is defined)

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst_b  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk externally
- req  input  N  per-requester request level, bit i = requester i
- ack  input  1  current grant consumed this cycle (one transfer done)
- lock  input  1  sampled with ack; 1 = winner keeps the grant after this transfer
- gnt  output  N  one-hot grant, registered
- gnt_vld  output  1  gnt is valid (OR of gnt)
- gnt_idx  output  IDX_W  binary index of the granted requester; holds its last value while gnt_vld=0
- any_req  output  1  combinational OR-reduction of req
- wdog_to  output  1  one-cycle watchdog timeout pulse; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst_b=0, async):
  - gnt=0, gnt_vld=0, gnt_idx=0, wdog_to=0.
  - Round-robin pointer ptr=0; state IDLE.
  - Applies mid-grant: the grant drops immediately and no release is signalled.
- Arbitration function:
  - Winner = first i with req[i]=1, scanning i = ptr, ptr+1, ... modulo N.
  - Evaluated combinationally; registered into gnt/gnt_idx.
  - Latency: req rise to gnt = 1 cycle.
- States: IDLE, GRANT, LOCKED.
- IDLE:
  - gnt_vld=0.
  - If any_req=1: register winner, go to GRANT. Otherwise stay in IDLE.
  - ack ignored while gnt_vld=0.
- GRANT:
  - gnt held stable while req[gnt_idx]=1 and ack=0.
  - ack=1 & lock=0:
    - ptr <= gnt_idx+1 mod N (N-1 wraps to 0).
    - If any_req this cycle: arbitrate using the new ptr and register the new winner next cycle (back-to-back, no bubble; the previous winner is lowest priority). Otherwise go to IDLE.
  - ack=1 & lock=1: same grant kept, ptr unchanged, go to LOCKED.
  - ack=0 & req[gnt_idx]=0 (withdrawal): grant dropped next cycle, ptr unchanged, go to IDLE.
  - Withdrawal and ack in the same cycle: ack takes priority.
- LOCKED:
  - Grant held unconditionally; req[gnt_idx] deassertion is ignored.
  - ack=1 & lock=0: release exactly as in GRANT.
  - ack=1 & lock=1: stay in LOCKED.
  - lock without ack: no effect.
- gnt is one-hot or zero in every cycle. gnt_vld == |gnt at all times.
- No starvation: with all N requesting and lock=0, each requester is granted within N grants.

Optional Feature:
- Macro: CTECH_LIB_OR_ARB_WDOG_EN.
- Defined:
  - An 8-bit counter clears on every ack and on entry to GRANT, and increments each cycle in GRANT/LOCKED without ack.
  - When the counter reaches WDOG_CYC-1 with no ack, a forced release occurs: behaves as ack=1 & lock=0 and overrides lock.
  - wdog_to=1 for that single cycle.
- Not defined: counter absent, wdog_to constant 0, grants held indefinitely.

Test Plan:
- Reset, then req=4'b0101 -> gnt=4'b0001, gnt_idx=0 one cycle later. ack=1 -> next cycle gnt=4'b0100, gnt_idx=2, no bubble.
- req=4'b1111 held, ack=1 every cycle, lock=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001. Each requester is granted once per 4 grants.
- Granted requester 1 asserts ack=1 with lock=1, then drops req[1] while others request -> gnt stays 4'b0010 (LOCKED). ack=1 with lock=0 -> gnt moves to the next requester after 1.
- Grant to requester 3, then req[3] falls with ack=0 -> gnt_vld=0 next cycle, ptr unchanged. Re-asserting req=4'b1001 -> requester 3 is granted again.
- Assert rst_b=0 mid-grant in LOCKED -> gnt=0 and gnt_vld=0 immediately (async). After release, req=4'b0010 -> gnt=4'b0010 with ptr restarted from 0.
- With CTECH_LIB_OR_ARB_WDOG_EN and WDOG_CYC=16: lock held, no ack for 16 cycles -> wdog_to pulses in cycle 16 of the grant, grant moves to the next requester. Without the macro the same stimulus leaves the grant held and wdog_to=0.
